// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder with a fixed latency.
// Accepts one load/store request at a time in IDLE, spends WAIT_CYCLES
// wait states, performs the memory access on the edge entering RESP and
// holds the response until the initiator consumes it.
//
// Ports
//   clk        : single clock, rising-edge
//   rst        : asynchronous reset, active low
//   req_valid  : request present           req_ready : request accepted this cycle
//   req_we     : 1 = store, 0 = load       req_addr  : byte address
//   req_wdata  : store data                req_be    : byte enables
//   resp_valid : response available        resp_ready: initiator consumes response
//   resp_rdata : load data (0 for stores and errors)
//   resp_err   : misaligned or out-of-range request
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          enter_resp;
  logic          mem_we;

  // With zero wait states the access happens on the acceptance edge itself,
  // before the request has been latched, so the live inputs are used then.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
  assign acc_idx = acc_addr[AW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The edge that takes the counter to zero is the one entering RESP.
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
    end
  end

  // Gating with rst keeps a store aborted by reset from reaching the array,
  // which itself is never cleared.
  assign mem_we = rst && enter_resp && acc_we && !acc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // req_ready is forced low while reset is held, even though the state is IDLE.
  assign req_ready  = rst && (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
